bcd_updown_counter_disp: RTL and testbench

- Parametrised successor to the two-digit seconds counter.
- N-digit BCD up/down counter with a built-in clock prescaler, synchronous load, pause, terminal-count pulse and registered active-low 7-segment outputs, one per digit.
- Sits between board switches/keys and the on-board 7-segment displays. Used for stopwatch, timer and countdown labs on the 50 MHz board clock.

---
 rtl/seg7_pkg.sv | 47 ++++
 rtl/bcd_updown_counter_disp_if.sv | 30 +++
 rtl/seg7_dec.sv | 35 +++
 rtl/bcd_updown_counter_disp.sv | 145 ++++++++++++++
 tb/tb_bcd_updown_counter_disp.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared constants and helpers for the BCD up/down counter with 7-segment
// display outputs.
//   SEG_BLANK, SEG_0..SEG_9 : active-low segment patterns, bit order {g..a}
//   int_to_bcd              : integer -> packed BCD (8 digits), elaboration use
//   bcd_to_int              : packed BCD (8 digits) -> integer
// -----------------------------------------------------------------------------
package seg7_pkg;

   typedef logic [3:0] bcd_digit_t;
   typedef logic [6:0] seg_t;

   localparam seg_t SEG_BLANK = 7'b1111111;
   localparam seg_t SEG_0     = 7'b1000000;
   localparam seg_t SEG_1     = 7'b1111001;
   localparam seg_t SEG_2     = 7'b0100100;
   localparam seg_t SEG_3     = 7'b0110000;
   localparam seg_t SEG_4     = 7'b0011001;
   localparam seg_t SEG_5     = 7'b0010010;
   localparam seg_t SEG_6     = 7'b0000010;
   localparam seg_t SEG_7     = 7'b1111000;
   localparam seg_t SEG_8     = 7'b0000000;
   localparam seg_t SEG_9     = 7'b0010000;

   function automatic logic [31:0] int_to_bcd(input int unsigned v);
      logic [31:0] r;
      int unsigned t;
      r = '0;
      t = v;
      for (int unsigned k = 0; k < 8; k++) begin
         r[4*k +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   function automatic int unsigned bcd_to_int(input logic [31:0] b);
      int unsigned r;
      r = 0;
      for (int unsigned k = 0; k < 8; k++) begin
         r = r * 10 + 32'(b[4*(7-k) +: 4]);
      end
      return r;
   endfunction

endpackage

// File: rtl/bcd_updown_counter_disp_if.sv
// -----------------------------------------------------------------------------
// bcd_updown_counter_disp_if
// Control and display bundle of the BCD up/down counter.
//   disp_en, pause, up, load, load_val : controls towards the counter
//   count_bcd, tick, rco, seg          : status/display from the counter
// master = board side driving the controls, slave = the counter itself.
// -----------------------------------------------------------------------------
interface bcd_updown_counter_disp_if #(
   parameter int unsigned DIGITS = 2
);
   logic                  disp_en;
   logic                  pause;
   logic                  up;
   logic                  load;
   logic [4*DIGITS-1:0]   load_val;
   logic [4*DIGITS-1:0]   count_bcd;
   logic                  tick;
   logic                  rco;
   logic [7*DIGITS-1:0]   seg;

   modport master (
      output disp_en, pause, up, load, load_val,
      input  count_bcd, tick, rco, seg
   );

   modport slave (
      input  disp_en, pause, up, load, load_val,
      output count_bcd, tick, rco, seg
   );
endinterface

// File: rtl/seg7_dec.sv
// -----------------------------------------------------------------------------
// seg7_dec
// Combinational BCD to active-low 7-segment decoder.
//   bcd_i   : BCD digit, codes 10..15 show blank
//   blank_i : 1 forces all segments off
//   seg_o   : active-low segments {g..a}
// -----------------------------------------------------------------------------
module seg7_dec
   import seg7_pkg::*;
(
   input  bcd_digit_t bcd_i,
   input  logic       blank_i,
   output seg_t       seg_o
);

   always_comb begin
      seg_o = SEG_BLANK;
      if (!blank_i) begin
         case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
         endcase
      end
   end

endmodule

// File: rtl/bcd_updown_counter_disp.sv
// -----------------------------------------------------------------------------
// bcd_updown_counter_disp
// N-digit BCD up/down counter with prescaler, synchronous load, pause,
// terminal-count pulse and registered active-low 7-segment outputs.
//   clk : system clock
//   rst : synchronous active-high reset
//   bus : slave side of bcd_updown_counter_disp_if
//         disp_en, pause, up, load, load_val in; count_bcd, tick, rco, seg out
// Parameters: DIGITS (1..8), DIV (>=2), MAX_VAL, LZB (leading-zero blanking).
// -----------------------------------------------------------------------------
module bcd_updown_counter_disp
   import seg7_pkg::*;
#(
   parameter int unsigned DIGITS  = 2,
   parameter int unsigned DIV     = 50000000,
   parameter int unsigned MAX_VAL = 99,
   parameter bit          LZB     = 1'b0
)(
   input  logic                         clk,
   input  logic                         rst,
   bcd_updown_counter_disp_if.slave     bus
);

   localparam int unsigned          PW         = $clog2(DIV);
   localparam logic [PW-1:0]        PRESC_LAST = PW'(DIV - 1);
   localparam logic [31:0]          MAX_BCD32  = int_to_bcd(MAX_VAL);
   localparam logic [4*DIGITS-1:0]  MAX_BCD    = MAX_BCD32[4*DIGITS-1:0];

   logic [PW-1:0]        presc_q, presc_d;
   logic                 tick_q, tick_d;
   logic                 rco_q, rco_d;
   logic [4*DIGITS-1:0]  count_q, count_d;
   logic [7*DIGITS-1:0]  seg_q, seg_d;

   logic [4*DIGITS-1:0]  inc_val, dec_val;
   logic                 carry, borrow;
   logic                 load_ok;
   logic [7*DIGITS-1:0]  seg_dec;

   // Decimal +1 / -1 ripple through the digit chain.
   always_comb begin
      inc_val = count_q;
      dec_val = count_q;
      carry   = 1'b1;
      borrow  = 1'b1;
      for (int unsigned k = 0; k < DIGITS; k++) begin
         if (carry) begin
            if (count_q[4*k +: 4] == 4'd9) begin
               inc_val[4*k +: 4] = 4'd0;
            end else begin
               inc_val[4*k +: 4] = count_q[4*k +: 4] + 4'd1;
               carry = 1'b0;
            end
         end
         if (borrow) begin
            if (count_q[4*k +: 4] == 4'd0) begin
               dec_val[4*k +: 4] = 4'd9;
            end else begin
               dec_val[4*k +: 4] = count_q[4*k +: 4] - 4'd1;
               borrow = 1'b0;
            end
         end
      end
   end

   // Once every digit is a legal BCD code, packed-BCD magnitude order equals
   // numeric order, so the range check is a plain vector compare.
   always_comb begin
      load_ok = (bus.load_val <= MAX_BCD);
      for (int unsigned k = 0; k < DIGITS; k++) begin
         if (bus.load_val[4*k +: 4] > 4'd9) begin
            load_ok = 1'b0;
         end
      end
   end

   always_comb begin
      presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
      tick_d  = (presc_q == PRESC_LAST);
      count_d = count_q;
      rco_d   = 1'b0;
      if (bus.load) begin
         presc_d = '0;
         tick_d  = 1'b0;
         count_d = load_ok ? bus.load_val : '0;
      end else if (tick_q && !bus.pause) begin
         if (bus.up) begin
            if (count_q == MAX_BCD) begin
               count_d = '0;
               rco_d   = 1'b1;
            end else begin
               count_d = inc_val;
            end
         end else begin
            if (count_q == '0) begin
               count_d = MAX_BCD;
               rco_d   = 1'b1;
            end else begin
               count_d = dec_val;
            end
         end
      end
   end

   for (genvar k = 0; k < DIGITS; k++) begin : g_dig
      logic blank;
      if (k == 0) begin : g_lsd
         assign blank = 1'b0;
      end else begin : g_upper
         // Blank only while this digit and every higher digit are zero.
         assign blank = LZB && (count_q[4*DIGITS-1:4*k] == '0);
      end
      seg7_dec u_dec (
         .bcd_i   (count_q[4*k +: 4]),
         .blank_i (blank),
         .seg_o   (seg_dec[7*k +: 7])
      );
   end

   always_comb begin
      seg_d = bus.disp_en ? seg_dec : '1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         presc_q <= '0;
         tick_q  <= 1'b0;
         rco_q   <= 1'b0;
         count_q <= '0;
         seg_q   <= '1;
      end else begin
         presc_q <= presc_d;
         tick_q  <= tick_d;
         rco_q   <= rco_d;
         count_q <= count_d;
         seg_q   <= seg_d;
      end
   end

   assign bus.count_bcd = count_q;
   assign bus.tick      = tick_q;
   assign bus.rco       = rco_q;
   assign bus.seg       = seg_q;

endmodule

// File: tb/tb_bcd_updown_counter_disp.sv
// -----------------------------------------------------------------------------
// tb_bcd_updown_counter_disp
// Two counter instances share one set of controls:
//   A: DIGITS=2, DIV=4, MAX_VAL=99, LZB=0
//   B: DIGITS=3, DIV=3, MAX_VAL=59, LZB=1
// An integer-level model predicts every output; directed phases follow, then
// randomized control traffic.
// -----------------------------------------------------------------------------
module tb_bcd_updown_counter_disp;

   logic        clk;
   logic        rst;
   logic        disp_en, pause, up, load;
   logic [11:0] lv;

   int checks = 0;
   int errors = 0;

   bcd_updown_counter_disp_if #(.DIGITS(2)) ifa ();
   bcd_updown_counter_disp_if #(.DIGITS(3)) ifb ();

   assign ifa.disp_en  = disp_en;
   assign ifa.pause    = pause;
   assign ifa.up       = up;
   assign ifa.load     = load;
   assign ifa.load_val = lv[7:0];
   assign ifb.disp_en  = disp_en;
   assign ifb.pause    = pause;
   assign ifb.up       = up;
   assign ifb.load     = load;
   assign ifb.load_val = lv;

   bcd_updown_counter_disp #(.DIGITS(2), .DIV(4), .MAX_VAL(99), .LZB(1'b0)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (ifa)
   );

   bcd_updown_counter_disp #(.DIGITS(3), .DIV(3), .MAX_VAL(59), .LZB(1'b1)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (ifb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   int unsigned m_div [2] = '{4, 3};
   int unsigned m_max [2] = '{99, 59};
   int          m_dig [2] = '{2, 3};
   bit          m_lzb [2] = '{1'b0, 1'b1};
   logic [6:0]  PAT  [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                              7'b0000000, 7'b0010000};

   int unsigned m_presc [2];
   int unsigned m_cnt   [2];
   bit          m_tick  [2];
   bit          m_rco   [2];
   logic [20:0] m_seg   [2];
   bit          m_valid = 1'b0;

   function automatic logic [11:0] to_bcd12(input int unsigned v);
      return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   function automatic logic [20:0] exp_seg(input int i, input int unsigned cnt, input logic en);
      logic [20:0] r;
      int unsigned pw;
      r  = '1;
      pw = 1;
      if (en) begin
         for (int k = 0; k < m_dig[i]; k++) begin
            if (!(k > 0 && m_lzb[i] && cnt < pw)) r[7*k +: 7] = PAT[(cnt / pw) % 10];
            pw = pw * 10;
         end
      end
      return r;
   endfunction

   task automatic model_step(input int i);
      int unsigned val, nd;
      bit ok;
      if (rst) begin
         m_presc[i] = 0; m_tick[i] = 1'b0; m_cnt[i] = 0; m_rco[i] = 1'b0; m_seg[i] = '1;
         return;
      end
      m_seg[i] = exp_seg(i, m_cnt[i], disp_en);
      m_rco[i] = 1'b0;
      if (load) begin
         ok  = 1'b1;
         val = 0;
         for (int k = m_dig[i] - 1; k >= 0; k--) begin
            nd = (32'(lv) >> (4 * k)) & 32'd15;
            if (nd > 9) ok = 1'b0;
            val = val * 10 + nd;
         end
         if (val > m_max[i]) ok = 1'b0;
         m_cnt[i]   = ok ? val : 0;
         m_presc[i] = 0;
         m_tick[i]  = 1'b0;
      end else begin
         if (m_tick[i] && !pause) begin
            if (up) begin
               if (m_cnt[i] == m_max[i]) begin m_cnt[i] = 0; m_rco[i] = 1'b1; end
               else m_cnt[i] = m_cnt[i] + 1;
            end else begin
               if (m_cnt[i] == 0) begin m_cnt[i] = m_max[i]; m_rco[i] = 1'b1; end
               else m_cnt[i] = m_cnt[i] - 1;
            end
         end
         m_tick[i]  = (m_presc[i] == m_div[i] - 1);
         m_presc[i] = (m_presc[i] + 1) % m_div[i];
      end
   endtask

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) model_step(i);
      if (rst) m_valid = 1'b1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- cycle compare ----------------
   always @(negedge clk) begin
      if (m_valid) begin
         chk("a.count", 32'(ifa.count_bcd), 32'(to_bcd12(m_cnt[0])));
         chk("a.tick",  32'(ifa.tick),      32'(m_tick[0]));
         chk("a.rco",   32'(ifa.rco),       32'(m_rco[0]));
         chk("a.seg",   32'({7'h7F, ifa.seg}), 32'(m_seg[0]));
         chk("b.count", 32'(ifb.count_bcd), 32'(to_bcd12(m_cnt[1])));
         chk("b.tick",  32'(ifb.tick),      32'(m_tick[1]));
         chk("b.rco",   32'(ifb.rco),       32'(m_rco[1]));
         chk("b.seg",   32'(ifb.seg),       32'(m_seg[1]));
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int n;
      int ticks;
      rst = 1'b1; disp_en = 1'b1; pause = 1'b0; up = 1'b1; load = 1'b0; lv = '0;
      repeat (3) @(negedge clk);
      chk("rst.a.count", 32'(ifa.count_bcd), 32'h0);
      chk("rst.a.seg",   32'(ifa.seg),       32'h3FFF);
      chk("rst.b.seg",   32'(ifb.seg),       32'h1FFFFF);
      rst = 1'b0;

      // first tick DIV cycles after reset release, then steps 01, 02
      repeat (4) @(negedge clk);
      chk("up.first_tick", 32'(ifa.tick), 32'h1);
      chk("up.count00",    32'(ifa.count_bcd), 32'h00);
      @(negedge clk);
      chk("up.count01",    32'(ifa.count_bcd), 32'h01);
      chk("up.seg0",       32'(ifa.seg[6:0]),  32'(7'b1000000));
      @(negedge clk);
      chk("up.seg1",       32'(ifa.seg[6:0]),  32'(7'b1111001));
      repeat (3) @(negedge clk);
      chk("up.count02",    32'(ifa.count_bcd), 32'h02);

      // 98 -> 99 -> 00 with rco -> 01
      load = 1'b1; lv = 12'h098;
      @(negedge clk);
      load = 1'b0;
      chk("load.a98", 32'(ifa.count_bcd), 32'h98);
      chk("load.b_over_max", 32'(ifb.count_bcd), 32'h000);
      n = 0;
      while (ifa.rco !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      chk("wrap.a_rco_seen", 32'(ifa.rco), 32'h1);
      chk("wrap.a_count00",  32'(ifa.count_bcd), 32'h00);
      @(negedge clk);
      chk("wrap.a_rco_once", 32'(ifa.rco), 32'h0);
      n = 0;
      while (ifa.count_bcd == 8'h00 && n < 10) begin @(negedge clk); n++; end
      chk("wrap.a_count01",  32'(ifa.count_bcd), 32'h01);

      // down from 00 wraps to MAX_VAL
      up = 1'b0; load = 1'b1; lv = 12'h000;
      @(negedge clk);
      load = 1'b0;
      n = 0;
      while (ifb.rco !== 1'b1 && n < 10) begin @(negedge clk); n++; end
      chk("down.b_rco_seen", 32'(ifb.rco), 32'h1);
      chk("down.b_count59",  32'(ifb.count_bcd), 32'h059);
      chk("model.b_wrap",    32'(m_cnt[1]), 32'd59);
      n = 0;
      while (ifa.rco !== 1'b1 && n < 10) begin @(negedge clk); n++; end
      chk("down.a_rco_seen", 32'(ifa.rco), 32'h1);
      chk("down.a_count99",  32'(ifa.count_bcd), 32'h99);
      up = 1'b1;

      // pause at 42 across several ticks
      load = 1'b1; lv = 12'h042; pause = 1'b1;
      @(negedge clk);
      load = 1'b0;
      ticks = 0;
      repeat (14) begin @(negedge clk); if (ifa.tick) ticks++; end
      chk("pause.a_held", 32'(ifa.count_bcd), 32'h42);
      chk("pause.ticks",  32'(ticks >= 3), 32'h1);
      pause = 1'b0;
      n = 0;
      while (ifa.count_bcd == 8'h42 && n < 10) begin @(negedge clk); n++; end
      chk("pause.a_resume43", 32'(ifa.count_bcd), 32'h43);

      // illegal / out-of-range loads, load on tick cycle
      load = 1'b1; lv = 12'h07A;
      @(negedge clk);
      chk("badload.a", 32'(ifa.count_bcd), 32'h00);
      chk("badload.b", 32'(ifb.count_bcd), 32'h000);
      lv = 12'h060;
      @(negedge clk);
      load = 1'b0;
      chk("load60.a", 32'(ifa.count_bcd), 32'h60);
      chk("load60.b_over_max", 32'(ifb.count_bcd), 32'h000);
      n = 0;
      while (ifa.tick !== 1'b1 && n < 10) begin @(negedge clk); n++; end
      chk("loadtick.tick_seen", 32'(ifa.tick), 32'h1);
      load = 1'b1; lv = 12'h015;
      @(negedge clk);
      load = 1'b0;
      chk("loadtick.a15", 32'(ifa.count_bcd), 32'h15);
      repeat (3) @(negedge clk);
      chk("loadtick.a_nostep", 32'(ifa.count_bcd), 32'h15);

      // leading-zero blanking and display enable
      load = 1'b1; lv = 12'h007; pause = 1'b1;
      @(negedge clk);
      load = 1'b0;
      @(negedge clk);
      chk("lzb.b_seg", 32'(ifb.seg), 32'({7'h7F, 7'h7F, 7'b1111000}));
      chk("lzb.a_seg", 32'(ifa.seg), 32'({7'b1000000, 7'b1111000}));
      disp_en = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("dispoff.a_seg", 32'(ifa.seg), 32'h3FFF);
      chk("dispoff.b_seg", 32'(ifb.seg), 32'h1FFFFF);
      disp_en = 1'b1; pause = 1'b0;

      // reset mid-count
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst.a_count", 32'(ifa.count_bcd), 32'h00);
      chk("midrst.b_count", 32'(ifb.count_bcd), 32'h000);
      chk("midrst.a_seg",   32'(ifa.seg), 32'h3FFF);

      // randomized traffic
      repeat (4000) begin
         @(negedge clk);
         rst  = ($urandom_range(0, 299) == 0);
         load = ($urandom_range(0, 24) == 0);
         if ($urandom_range(0, 19) == 0) pause = ~pause;
         if ($urandom_range(0, 29) == 0) up = ~up;
         disp_en = ($urandom_range(0, 15) != 0);
         case ($urandom_range(0, 3))
            0:       lv = 12'($urandom);
            1:       lv = to_bcd12($urandom_range(0, 999));
            default: lv = to_bcd12($urandom_range(0, 99));
         endcase
      end
      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
